// File: rtl/gpi_ctrl_if.sv
// Bus port of gpi_ctrl: fsb chip select, word address, direction and data.
interface gpi_ctrl_if;
  // Transfer semantics: en is the valid; the slave is always ready. A write
  // commits on the rising clk edge where en=1 and drw=1; with en=1 and drw=0
  // dout carries the addressed register combinationally in that same cycle.
  logic        en;
  logic [31:0] addr;
  logic        drw;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output en, output addr, output drw, output din, input dout);
  modport slave  (input en, input addr, input drw, input din, output dout);
endinterface

// File: rtl/gpi_ctrl.sv
// Memory-mapped GPI controller: sync, tick debounce, sticky edge status, masked irq.
// Optional per-bit rising/falling edge select at offset 4 under GPI_EDGE_SEL_EN.
module gpi_ctrl #(
  parameter int          WIDTH      = 8,
  parameter logic [15:0] DB_DEFAULT = 16'd50000
) (
  input  logic             clk,
  input  logic             rst,
  gpi_ctrl_if.slave        bus,
  input  logic [WIDTH-1:0] gpi,
  output logic             irq
);

  localparam logic [2:0] OFF_VALUE  = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_MASK   = 3'd2;
  localparam logic [2:0] OFF_DBR    = 3'd3;
`ifdef GPI_EDGE_SEL_EN
  localparam logic [2:0] OFF_EDGE   = 3'd4;
`endif

  logic             wr_en;
  logic [2:0]       off;
  logic [WIDTH-1:0] din_w;
  logic             unused_bits;

  logic [WIDTH-1:0] sync1, sync2, hist0, hist1;
  logic [WIDTH-1:0] value, status, mask;
  logic [15:0]      dbr, presc;
  logic             tick;
  logic [WIDTH-1:0] stable_hi, stable_lo, value_nxt, evt, clr, status_nxt;
  logic [31:0]      rdata;
`ifdef GPI_EDGE_SEL_EN
  logic [WIDTH-1:0] edge_sel, rise, fall;
`endif

  assign wr_en       = bus.en & bus.drw;
  assign off         = bus.addr[4:2];
  assign din_w       = bus.din[WIDTH-1:0];
  assign unused_bits = &{1'b0, bus.addr[31:5], bus.addr[1:0], bus.din};

  always_comb begin
    tick      = (presc == dbr);
    // A level is accepted once the current sample and both older tick samples agree.
    stable_hi = sync2 & hist0 & hist1;
    stable_lo = ~(sync2 | hist0 | hist1);
    value_nxt = tick ? ((value | stable_hi) & ~stable_lo) : value;
`ifdef GPI_EDGE_SEL_EN
    rise      = value_nxt & ~value;
    fall      = value & ~value_nxt;
    evt       = (rise & edge_sel) | (fall & ~edge_sel);
`else
    evt       = value_nxt ^ value;
`endif
    clr        = (wr_en && off == OFF_STATUS) ? din_w : '0;
    // Set beats clear when an event lands in the same cycle as the W1C write.
    status_nxt = (status & ~clr) | evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      hist0    <= '0;
      hist1    <= '0;
      value    <= '0;
      status   <= '0;
      mask     <= '0;
      dbr      <= DB_DEFAULT;
      presc    <= '0;
      irq      <= 1'b0;
`ifdef GPI_EDGE_SEL_EN
      edge_sel <= '0;
`endif
    end else begin
      sync1  <= gpi;
      sync2  <= sync1;
      if (wr_en && off == OFF_DBR) presc <= '0;
      else if (tick)               presc <= '0;
      else                         presc <= presc + 16'd1;
      if (tick) begin
        hist0 <= sync2;
        hist1 <= hist0;
      end
      value  <= value_nxt;
      status <= status_nxt;
      irq    <= |(status_nxt & mask);
      if (wr_en && off == OFF_MASK) mask <= din_w;
      if (wr_en && off == OFF_DBR)  dbr  <= bus.din[15:0];
`ifdef GPI_EDGE_SEL_EN
      if (wr_en && off == OFF_EDGE) edge_sel <= din_w;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.en && !bus.drw) begin
      case (off)
        OFF_VALUE:  rdata[WIDTH-1:0] = value;
        OFF_STATUS: rdata[WIDTH-1:0] = status;
        OFF_MASK:   rdata[WIDTH-1:0] = mask;
        OFF_DBR:    rdata[15:0]      = dbr;
`ifdef GPI_EDGE_SEL_EN
        OFF_EDGE:   rdata[WIDTH-1:0] = edge_sel;
`endif
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.dout = rdata;

endmodule
